// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle controller for the shared MIPS-subset datapath: sequences fetch,
// decode, execute, memory and writeback steps and counts retired instructions.
//
// state    | meaning
// IDLE     | parked after reset or bus error
// FETCH    | read instruction at PC, PC += 4
// DECODE   | decode op/func, precompute branch target
// EXEC_R   | ALU op on rs, rt
// WB_R     | write ALUOut to rd
// ADDR     | compute lw/sw effective address
// MEM_RD   | load data read
// WB_LW    | write MDR to rt
// MEM_WR   | store data write
// BRANCH   | compare rs, rt; take branch on zero
// EXEC_LUI | form imm << 16
// WB_LUI   | write ALUOut to rt
module multicycle_ctrl_fsm #(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             pc_src,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_WB_R     = 4'd4;
  localparam logic [3:0] S_ADDR     = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_WB_LW    = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_EXEC_LUI = 4'd10;
  localparam logic [3:0] S_WB_LUI   = 4'd11;

  localparam logic [7:0] WAIT_RELOAD = 8'(WAIT_LIMIT - 1);

  logic [3:0]       state_q, state_d;
  logic [7:0]       wait_left;
  logic             is_store;
  logic             bus_err_q;
  logic [CNT_W-1:0] retired_q;

  logic op_r, op_lw, op_sw, op_beq, op_lui, func_ok, decode_ok;
  logic waiting, timeout, retire;

  assign op_r   = (op == 6'b000000);
  assign op_lw  = (op == 6'b100011);
  assign op_sw  = (op == 6'b101011);
  assign op_beq = (op == 6'b000100);
  assign op_lui = (op == 6'b001111);

  always_comb begin
    func_ok = 1'b0;
    case (func)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110: func_ok = 1'b1;
      default: func_ok = 1'b0;
    endcase
  end

  assign decode_ok = (op_r && func_ok) || op_lw || op_sw || op_beq || op_lui;

  // Down-counter reloads on every state change; terminal count with no
  // mem_ready is the timeout, so a late mem_ready still wins the race.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                   && !mem_ready;
  assign timeout = waiting && (wait_left == 8'd0);

  assign retire = (state_q == S_WB_R) || (state_q == S_WB_LW) || (state_q == S_BRANCH) ||
                  (state_q == S_WB_LUI) || ((state_q == S_MEM_WR) && mem_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = bus_err_q ? S_IDLE : S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE; else if (timeout) state_d = S_IDLE;
      S_DECODE: begin
        if (op_r && func_ok)      state_d = S_EXEC_R;
        else if (op_lw || op_sw)  state_d = S_ADDR;
        else if (op_beq)          state_d = S_BRANCH;
        else if (op_lui)          state_d = S_EXEC_LUI;
        else                      state_d = S_FETCH;
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_ADDR:     state_d = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_LW; else if (timeout) state_d = S_IDLE;
      S_WB_LW:    state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH; else if (timeout) state_d = S_IDLE;
      S_BRANCH:   state_d = S_FETCH;
      S_EXEC_LUI: state_d = S_WB_LUI;
      S_WB_LUI:   state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_left <= 8'd0;
      is_store  <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_left <= WAIT_RELOAD;
      else if (waiting)
        wait_left <= wait_left - 8'd1;
      if (timeout)
        bus_err_q <= 1'b1;
      // op is only trusted in DECODE; ADDR steers on the latched store flag
      if (state_q == S_DECODE)
        is_store <= op_sw;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_we     = mem_ready;
        ir_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = !decode_ok;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (func)
          6'b100010: alu_op = 3'b001;
          6'b100100: alu_op = 3'b010;
          6'b100101: alu_op = 3'b011;
          6'b100110: alu_op = 3'b100;
          default:   alu_op = 3'b000;
        endcase
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_src    = 1'b1;
        pc_we     = zero;
      end
      S_EXEC_LUI: begin
        alu_src_b = 2'b10;
        alu_op    = 3'b101;
      end
      S_WB_LUI:   reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm (CNT_W=2, WAIT_LIMIT=4): stimulus
// pushes per-cycle expectations, a negedge monitor pops and compares them.
module tb_multicycle_ctrl_fsm;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3, ST_WB_R = 4'd4, ST_ADDR = 4'd5, ST_MEM_RD = 4'd6,
    ST_WB_LW = 4'd7, ST_MEM_WR = 4'd8, ST_BRANCH = 4'd9, ST_EXEC_LUI = 4'd10,
    ST_WB_LUI = 4'd11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_LUI = 6'b001111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
    F_OR = 6'b100101, F_XOR = 6'b100110;

  logic clk, rst_n, zero, mem_ready;
  logic [5:0] op, func;
  logic pc_we, ir_we, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic alu_src_a, pc_src, illegal, bus_err;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [1:0] retired;

  multicycle_ctrl_fsm #(.CNT_W(2), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [1:0]  ret;
    logic        bus;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] exp_ret;
  logic       exp_bus;

  // {pc_we, ir_we, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b, alu_op, pc_src, illegal}
  function automatic logic [15:0] exp_ctrl(input logic [3:0] es, input logic [5:0] f,
                                           input logic z, input logic mr, input logic ill);
    logic pw, iw, io, mrd, mwr, rw, rd, m2r, sa, ps;
    logic [1:0] sbv;
    logic [2:0] ao;
    {pw, iw, io, mrd, mwr, rw, rd, m2r, sa, ps} = '0;
    sbv = 2'b00;
    ao  = 3'b000;
    case (es)
      ST_FETCH:    begin mrd = 1; sbv = 2'b01; pw = mr; iw = mr; end
      ST_DECODE:   sbv = 2'b11;
      ST_EXEC_R: begin
        sa = 1;
        if (f == F_SUB) ao = 3'b001;
        else if (f == F_AND) ao = 3'b010;
        else if (f == F_OR) ao = 3'b011;
        else if (f == F_XOR) ao = 3'b100;
      end
      ST_WB_R:     begin rw = 1; rd = 1; end
      ST_ADDR:     begin sa = 1; sbv = 2'b10; end
      ST_MEM_RD:   begin mrd = 1; io = 1; end
      ST_WB_LW:    begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin mwr = 1; io = 1; end
      ST_BRANCH:   begin sa = 1; ao = 3'b001; ps = 1; pw = z; end
      ST_EXEC_LUI: begin sbv = 2'b10; ao = 3'b101; end
      ST_WB_LUI:   rw = 1;
      default: ;
    endcase
    return {pw, iw, io, mrd, mwr, rw, rd, m2r, sa, sbv, ao, ps, ill};
  endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic mr, input logic [3:0] es, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; op = o; func = f; zero = z; mem_ready = mr;
    if (!r) begin
      exp_ret = 2'd0;
      exp_bus = 1'b0;
    end
    e.st   = es;
    e.ctrl = exp_ctrl(es, f, z, mr, ill);
    e.ret  = exp_ret;
    e.bus  = exp_bus;
    sb.push_back(e);
  endtask

  task automatic do_r(input logic [5:0] f);
    step(1, OP_R, f, 0, 1, ST_FETCH, 0);
    step(1, OP_R, f, 0, 1, ST_DECODE, 0);
    step(1, OP_R, f, 0, 1, ST_EXEC_R, 0);
    step(1, OP_R, f, 0, 1, ST_WB_R, 0);
    exp_ret = exp_ret + 2'd1;
  endtask

  // op outside DECODE is deliberately the other memory opcode
  task automatic do_lw(input int nwait);
    step(1, OP_SW, 0, 0, 1, ST_FETCH, 0);
    step(1, OP_LW, 0, 0, 1, ST_DECODE, 0);
    step(1, OP_SW, 0, 0, 1, ST_ADDR, 0);
    for (int i = 0; i < nwait; i++) step(1, OP_SW, 0, 0, 0, ST_MEM_RD, 0);
    step(1, OP_SW, 0, 0, 1, ST_MEM_RD, 0);
    step(1, OP_SW, 0, 0, 1, ST_WB_LW, 0);
    exp_ret = exp_ret + 2'd1;
  endtask

  task automatic do_sw(input int nwait);
    step(1, OP_LW, 0, 0, 1, ST_FETCH, 0);
    step(1, OP_SW, 0, 0, 1, ST_DECODE, 0);
    step(1, OP_LW, 0, 0, 1, ST_ADDR, 0);
    for (int i = 0; i < nwait; i++) step(1, OP_LW, 0, 0, 0, ST_MEM_WR, 0);
    step(1, OP_LW, 0, 0, 1, ST_MEM_WR, 0);
    exp_ret = exp_ret + 2'd1;
  endtask

  task automatic do_beq(input logic z);
    step(1, OP_BEQ, 0, z, 1, ST_FETCH, 0);
    step(1, OP_BEQ, 0, z, 1, ST_DECODE, 0);
    step(1, OP_BEQ, 0, z, 1, ST_BRANCH, 0);
    exp_ret = exp_ret + 2'd1;
  endtask

  task automatic do_lui();
    step(1, OP_LUI, 0, 0, 1, ST_FETCH, 0);
    step(1, OP_LUI, 0, 0, 1, ST_DECODE, 0);
    step(1, OP_LUI, 0, 0, 1, ST_EXEC_LUI, 0);
    step(1, OP_LUI, 0, 0, 1, ST_WB_LUI, 0);
    exp_ret = exp_ret + 2'd1;
  endtask

  task automatic do_illegal(input logic [5:0] o, input logic [5:0] f);
    step(1, o, f, 0, 1, ST_FETCH, 0);
    step(1, o, f, 0, 1, ST_DECODE, 1);
  endtask

  initial begin : monitor
    exp_t e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        act = {pc_we, ir_we, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal};
        n_cmp++;
        if (state !== e.st) begin
          n_bad++;
          $display("FAIL state @%0t: got %0d want %0d", $time, state, e.st);
        end
        n_cmp++;
        if (act !== e.ctrl) begin
          n_bad++;
          $display("FAIL ctrl @%0t (state %0d): got %b want %b", $time, e.st, act, e.ctrl);
        end
        n_cmp++;
        if (retired !== e.ret) begin
          n_bad++;
          $display("FAIL retired @%0t: got %0d want %0d", $time, retired, e.ret);
        end
        n_cmp++;
        if (bus_err !== e.bus) begin
          n_bad++;
          $display("FAIL bus_err @%0t: got %b want %b", $time, bus_err, e.bus);
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    exp_ret = 2'd0; exp_bus = 1'b0;

    step(0, 0, 0, 0, 0, ST_IDLE, 0);
    step(0, 0, 0, 0, 1, ST_IDLE, 0);
    step(1, 0, 0, 0, 1, ST_IDLE, 0);

    do_r(F_ADD); do_r(F_SUB); do_r(F_AND); do_r(F_OR); do_r(F_XOR);
    do_lw(3); do_lw(0);
    do_sw(0); do_sw(2);
    do_beq(1'b1); do_beq(1'b0);
    do_illegal(OP_R, 6'b000111);
    do_illegal(6'b111111, F_ADD);
    do_lui();

    // mem_ready arriving in the limit cycle wins over the timeout
    repeat (3) step(1, OP_R, F_ADD, 0, 0, ST_FETCH, 0);
    do_r(F_ADD);

    // reset while a store waits: write drops at once, counters clear
    step(1, OP_SW, 0, 0, 1, ST_FETCH, 0);
    step(1, OP_SW, 0, 0, 1, ST_DECODE, 0);
    step(1, OP_SW, 0, 0, 1, ST_ADDR, 0);
    step(1, OP_SW, 0, 0, 0, ST_MEM_WR, 0);
    step(0, OP_SW, 0, 0, 0, ST_IDLE, 0);
    step(1, OP_SW, 0, 0, 0, ST_IDLE, 0);

    repeat (4) do_sw(0);

    // fetch timeout: bus_err sticks, IDLE holds until reset
    repeat (4) step(1, OP_R, F_ADD, 0, 0, ST_FETCH, 0);
    exp_bus = 1'b1;
    repeat (3) step(1, OP_R, F_ADD, 0, 1, ST_IDLE, 0);
    step(0, OP_R, F_ADD, 0, 1, ST_IDLE, 0);
    step(1, OP_R, F_ADD, 0, 1, ST_IDLE, 0);
    do_r(F_ADD);
    step(1, OP_R, F_ADD, 0, 0, ST_FETCH, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
